// File: rtl/token_expand_sched_pkg.sv
// ----------------------------------------------------------------------------
// token_sched_pkg
// Shared types and defaults for the token expansion scheduler.
//   state_t      : scheduler FSM states (IDLE / EMIT / GAP)
//   MAX_RUN_DEF  : default largest accepted burst length, in tokens
//   FACTOR_DEF   : default output '1' cycles per token (original + two doubles)
//   LEN_W        : width of one requester's burst length field
//   emit_cycles  : number of high cycles a burst of a given length produces
// ----------------------------------------------------------------------------
package token_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_RUN_DEF = 200;
    localparam int FACTOR_DEF  = 3;
    localparam int LEN_W       = 8;

    function automatic int emit_cycles(input int len, input int factor);
        return len * factor;
    endfunction

endpackage

// File: rtl/token_expand_sched_if.sv
// ----------------------------------------------------------------------------
// token_expand_sched_if
// Request handshake bundle between the requesters and the scheduler.
//   req_valid : per-requester burst request (held until accepted)
//   req_len   : per-requester burst length in tokens (held until accepted)
//   req_ready : one-hot acceptance strobe from the scheduler
// Modports:
//   master : requester side (drives valid/len, observes ready)
//   slave  : scheduler side (observes valid/len, drives ready)
// ----------------------------------------------------------------------------
interface token_expand_sched_if #(
    parameter int N_REQ = 4
);
    import token_sched_pkg::*;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][LEN_W-1:0] req_len;
    logic [N_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_len,
        output req_ready
    );

endinterface

// File: rtl/token_expand_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req     : request vector, one bit per requester
//   last_id : id granted most recently; the search starts one position after it
//   gnt     : one-hot grant (all zero when no request is pending)
//   gnt_id  : binary index of the granted requester (0 when nothing granted)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id
);

    int   idx;
    logic found;

    // Walk the ring starting just past last_id; the first set request wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/token_expand_sched.sv
// ----------------------------------------------------------------------------
// token_expand_sched
// Accepts burst requests from N_REQ requesters round-robin and expands each
// accepted burst of len tokens into len*FACTOR consecutive '1' cycles on b,
// followed by one mandatory zero GAP cycle.
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-low reset
//   req      : request handshake (slave modport: req_valid, req_len, req_ready)
//   b        : registered serial expanded token stream
//   busy     : high while a burst is being emitted
//   grant_id : requester owning the current / most recent burst
//   overflow : sticky flag, set when a request longer than MAX_RUN is consumed
//   err_id   : requester that caused the first overflow
// ----------------------------------------------------------------------------
module token_expand_sched
    import token_sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int MAX_RUN = MAX_RUN_DEF,
    parameter  int FACTOR  = FACTOR_DEF,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    token_expand_sched_if.slave  req,
    output logic                 b,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 overflow,
    output logic [IDW-1:0]       err_id
);

    // Wide enough for the longest burst (MAX_RUN*FACTOR) without wrapping.
    localparam int CW = $clog2(MAX_RUN * FACTOR + 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    cnt_load;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   last_id_next;
    logic [IDW-1:0]   grant_id_next;
    logic [IDW-1:0]   err_id_next;
    logic             overflow_next;
    logic             armed;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic [LEN_W-1:0] sel_len;
    logic             accept;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req.req_valid),
        .last_id (last_id),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    // armed stays low for the first edge after reset release so that no
    // request can be accepted on that edge. Ready never looks at req_len.
    assign req.req_ready = (state == IDLE && armed) ? gnt : '0;
    assign accept        = |(req.req_ready & req.req_valid);
    assign sel_len       = req.req_len[gnt_id];

    // Counter holds the number of EMIT cycles still to go after the current
    // one, so it is loaded with len*FACTOR-1 on acceptance.
    assign cnt_load = CW'(emit_cycles(int'(sel_len), FACTOR) - 1);

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        last_id_next  = last_id;
        grant_id_next = grant_id;
        overflow_next = overflow;
        err_id_next   = err_id;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    last_id_next  = gnt_id;
                    grant_id_next = gnt_id;
                    if (int'(sel_len) > MAX_RUN) begin
                        // Consumed without emission; only the first offender
                        // is remembered.
                        overflow_next = 1'b1;
                        if (!overflow) begin
                            err_id_next = gnt_id;
                        end
                    end else if (sel_len != '0) begin
                        state_next = EMIT;
                        cnt_next   = cnt_load;
                    end
                end
            end
            EMIT: begin
                if (cnt == '0) begin
                    state_next = GAP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // b/busy are registered copies of "next state is EMIT", so they rise the
    // cycle after acceptance and carry no combinational path from inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_id  <= IDW'(N_REQ - 1);
            grant_id <= '0;
            overflow <= 1'b0;
            err_id   <= '0;
            armed    <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            last_id  <= last_id_next;
            grant_id <= grant_id_next;
            overflow <= overflow_next;
            err_id   <= err_id_next;
            armed    <= 1'b1;
            b        <= (state_next == EMIT);
            busy     <= (state_next == EMIT);
        end
    end

endmodule

// File: doc/token_expand_sched.md
TOKEN_EXPAND_SCHED -- requirements
Module: token_expand_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_RUN, default 200, giving the largest accepted burst length in tokens.
REQ-003 The block SHALL have parameter FACTOR, default 3, giving the output '1' cycles per input token (original plus two doubles).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, N_REQ bits: per-requester burst request.
REQ-007 The block SHALL have port req_len, input, N_REQ x 8 bits: per-requester burst length in tokens.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: one-hot acceptance strobe.
REQ-009 The block SHALL have port b, output, 1 bit: the serial expanded token stream.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a burst is being emitted.
REQ-011 The block SHALL have port grant_id, output, $clog2(N_REQ) bits: the requester owning the current burst.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky error flag.
REQ-013 The block SHALL have port err_id, output, $clog2(N_REQ) bits: the requester that caused the first overflow.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, EMIT and GAP, and SHALL leave reset in IDLE.
REQ-015 In IDLE with any req_valid set, the block SHALL pick one requester round-robin, starting one position after the last accepted id (id 0 first after reset).
REQ-016 The block SHALL assert req_ready for the picked requester only, for exactly one cycle in IDLE; a request is accepted on the edge where valid&&ready.
REQ-017 Requesters SHALL hold req_valid and req_len stable until accepted; req_ready SHALL NOT depend combinationally on req_len.
REQ-018 On acceptance the block SHALL latch req_len and the requester id, and SHALL drive grant_id with that id from the next cycle.
REQ-019 On acceptance with 1<=len<=MAX_RUN, the block SHALL go to EMIT and drive b=1, busy=1 for exactly len*FACTOR cycles, starting the cycle after acceptance.
REQ-020 After EMIT the block SHALL spend exactly one GAP cycle with b=0, busy=0, then return to IDLE; back-to-back bursts are therefore separated by at least 2 zero cycles (GAP plus IDLE).
REQ-021 On acceptance with len=0, the request SHALL be consumed with no emission, and the block SHALL stay in IDLE with the round-robin pointer advanced.
REQ-022 On acceptance with len>MAX_RUN, the request SHALL be consumed with no emission, overflow SHALL be set and the block SHALL stay in IDLE.
REQ-023 err_id SHALL latch the id only when overflow was previously 0; later overflows SHALL NOT change it.
REQ-024 overflow SHALL stay set until reset and SHALL NOT block further scheduling.
REQ-025 The down-counter SHALL be $clog2(MAX_RUN*FACTOR+1) bits wide, so the 600-cycle maximum must not wrap.
REQ-026 The block SHALL sample no requests in EMIT or GAP, and req_ready SHALL be all-zero in those states.
REQ-027 b SHALL be driven from a register, with no combinational path from any input.

Reset
REQ-028 Asserting rst (low) SHALL immediately force state=IDLE, b=0, busy=0, req_ready=0, grant_id=0, overflow=0, err_id=0, counter=0 and round-robin pointer=N_REQ-1.
REQ-029 A reset during EMIT SHALL abort the burst with no GAP cycle, and no request SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-030 A shared package token_sched_pkg SHALL hold the state enum (IDLE/EMIT/GAP) and the default constants for MAX_RUN and FACTOR.
REQ-031 Round-robin selection SHALL be a separate sub-module rr_arbiter(N_REQ) with inputs req and last_id and outputs one-hot gnt and gnt_id, purely combinational.
REQ-032 token_expand_sched SHALL instantiate rr_arbiter once and hold all state locally.

Verification
REQ-033 The bench SHALL hold req_valid=0001, len=1 -> ready[0] pulses once; b high 3 cycles starting the cycle after acceptance, then GAP.
REQ-034 The bench SHALL hold all four requesters valid with len=2 -> accept order 0,1,2,3; 6-cycle bursts, each separated by 2 zero cycles.
REQ-035 The bench SHALL issue len=200 on requester 2 -> b high 600 cycles, no overflow; then len=201 on requester 1 -> no emission, overflow=1, err_id=1.
REQ-036 After REQ-035, the bench SHALL issue len=255 on requester 3 -> overflow stays 1, err_id stays 1; a following len=1 is still emitted normally.
REQ-037 The bench SHALL issue len=0 on requester 0 with requester 1 also valid -> requester 0 consumed with no b activity; requester 1 accepted on the next IDLE cycle.
REQ-038 The bench SHALL pull rst low mid-burst at cycle 50 of 600 -> b, busy and overflow are 0 immediately; after release, the round-robin restarts at id 0.
